// File: rtl/tail_light_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_sequencer
// Purpose  : Six-lamp tail light sequencer. It synchronizes the driver
//            switches, divides clk down to a lamp step rate, arbitrates
//            left/right/hazard requests and overlays the brake lamps.
// Options  : TAIL_BRAKE_EN -- compiles in the brake synchronizer and overlay.
// Revision : 1.0  initial release
// ============================================================================
module tail_light_sequencer #(
  parameter int TICK_DIV = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic [5:0] y,
  output logic [1:0] mode,
  output logic       busy,
  output logic       step
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH1  = 2'd1,
    S_PH2  = 2'd2,
    S_PH3  = 2'd3
  } state_t;

  localparam logic [1:0]       c_mode_none   = 2'b00;
  localparam logic [1:0]       c_mode_left   = 2'b01;
  localparam logic [1:0]       c_mode_right  = 2'b10;
  localparam logic [1:0]       c_mode_hazard = 2'b11;
  localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(TICK_DIV - 1);

  // synchronizer stages, bit order {hazard, right, left}
  logic [2:0]       r_req_meta;
  logic [2:0]       r_req_sync;
  logic             w_brake_sync;

  logic [CNT_W-1:0] r_cnt;
  logic             w_step;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic [1:0]       w_mode_arb;
  logic             w_any_req;
  logic [5:0]       r_y;
  logic [5:0]       w_y_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [2:0]       w_fill;
  logic [2:0]       w_left_lamps;
  logic [2:0]       w_right_lamps;

  // two-flop synchronizers for the turn and hazard switches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req_meta <= '0;
      r_req_sync <= '0;
    end else begin
      r_req_meta <= {hazard_req, right_req, left_req};
      r_req_sync <= r_req_meta;
    end
  end

`ifdef TAIL_BRAKE_EN
  logic r_brake_meta;
  logic r_brake_sync;

  // two-flop synchronizer for the brake pedal
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_brake_meta <= 1'b0;
      r_brake_sync <= 1'b0;
    end else begin
      r_brake_meta <= brake;
      r_brake_sync <= r_brake_meta;
    end
  end

  assign w_brake_sync = r_brake_sync;
`else
  // brake stays on the port list but has no effect in this build
  logic w_unused_brake;
  assign w_unused_brake = brake;
  assign w_brake_sync   = 1'b0;
`endif

  // free-running prescaler; requests never disturb the step cadence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_step = (r_cnt == c_cnt_last);

  // hazard wins, and both turn switches together also mean hazard
  assign w_any_req  = |r_req_sync;
  assign w_mode_arb = (r_req_sync[2] || (r_req_sync[0] && r_req_sync[1])) ? c_mode_hazard :
                      r_req_sync[0] ? c_mode_left  :
                      r_req_sync[1] ? c_mode_right : c_mode_none;

  // sequencer state, latched mode and registered lamp outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= c_mode_none;
      r_y     <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_y     <= w_y_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // next phase/mode on a step, then the lamp pattern for that phase
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_fill        = 3'b000;
    w_left_lamps  = 3'b000;
    w_right_lamps = 3'b000;

    if (w_step) begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            w_state_nxt = S_PH1;
            w_mode_nxt  = w_mode_arb;
          end
        end
        S_PH1:   w_state_nxt = S_PH2;
        S_PH2:   w_state_nxt = S_PH3;
        default: begin
          w_state_nxt = S_IDLE;
          w_mode_nxt  = c_mode_none;
        end
      endcase
    end

    // lamps lit counting outward from the inner lamp, LSB = inner
    case (w_state_nxt)
      S_PH1:   w_fill = 3'b001;
      S_PH2:   w_fill = 3'b011;
      S_PH3:   w_fill = 3'b111;
      default: w_fill = 3'b000;
    endcase

    // brake lights every side that is not sequencing
    w_left_lamps  = {3{w_brake_sync}};
    w_right_lamps = {3{w_brake_sync}};
    case (w_mode_nxt)
      c_mode_left:  w_left_lamps  = w_fill;
      c_mode_right: w_right_lamps = {w_fill[0], w_fill[1], w_fill[2]};
      c_mode_hazard: begin
        w_left_lamps  = w_fill;
        w_right_lamps = {w_fill[0], w_fill[1], w_fill[2]};
      end
      default: ;
    endcase

    // left lamps occupy y[5:3] outer..inner, right lamps y[2:0] inner..outer
    w_y_nxt    = {w_left_lamps, w_right_lamps};
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign y    = r_y;
  assign mode = r_mode;
  assign busy = r_busy;
  assign step = w_step;

endmodule
`default_nettype wire
